msg_validator: RTL and testbench

Downstream consumer of the RC4 `datapath`: it checks the decrypted message bytes produced during the `S_MEM_DECRYPT` phase, one at a time, and decides whether the current candidate key is plausible. A message is accepted only if every byte is a lowercase ASCII letter (0x61–0x7A) or a space (0x20). On the first illegal byte the block raises `abort_req`, which is wired to the datapath `stop` input so the key can be abandoned early. The pass/fail result drives the key-search control and the `key_found_flag` indication.

---
 rtl/msg_validator.sv | 145 ++++++++++++++
 tb/tb_msg_validator.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_validator.sv
// Plausibility checker for RC4 candidate plaintext: accepts a key only if every byte is a-z or space.
// Optional capture of the checked bytes with registered readback is enabled by defining MSG_CAPTURE_EN.
module msg_validator #(
    parameter int MSG_LEN = 32,
    parameter int CNT_W   = $clog2(MSG_LEN) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             abort_req,
    output logic             key_found,
    output logic             check_done,
    output logic [CNT_W-1:0] bytes_checked,
    output logic [CNT_W-1:0] first_bad_index
`ifdef MSG_CAPTURE_EN
    ,
    input  logic [CNT_W-2:0] rd_addr,
    output logic [7:0]       rd_data
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        PASS  = 2'd2,
        FAIL  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    function automatic logic is_legal(input logic [7:0] b);
        is_legal = ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] bad_idx_r;
    logic [CNT_W-1:0] bad_idx_nxt_s;
    logic             key_found_r;
    logic             abort_r;
    logic             done_r;
    logic             accept_s;

    // Next-state and counter update; start overrides everything, including a coincident byte
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        bad_idx_nxt_s = bad_idx_r;
        accept_s      = 1'b0;
        if (start) begin
            state_nxt_s   = CHECK;
            cnt_nxt_s     = CNT_ZERO;
            bad_idx_nxt_s = CNT_ZERO;
        end else begin
            case (state_r)
                CHECK: begin
                    if (byte_valid) begin
                        accept_s = 1'b1;
                        if (is_legal(byte_data)) begin
                            cnt_nxt_s = cnt_r + CNT_ONE;
                            if (cnt_r == LAST_IDX) begin
                                state_nxt_s = PASS;
                            end else begin
                                state_nxt_s = CHECK;
                            end
                        end else begin
                            bad_idx_nxt_s = cnt_r;
                            state_nxt_s   = FAIL;
                        end
                    end else begin
                        state_nxt_s = CHECK;
                    end
                end
                IDLE, PASS, FAIL: begin
                    state_nxt_s = state_r;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State, counters and verdict flags; flags are decoded from the next state so they appear with it
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            bad_idx_r   <= CNT_ZERO;
            key_found_r <= 1'b0;
            abort_r     <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            bad_idx_r   <= bad_idx_nxt_s;
            key_found_r <= (state_nxt_s == PASS);
            abort_r     <= (state_nxt_s == FAIL);
            done_r      <= (state_nxt_s == PASS) || (state_nxt_s == FAIL);
        end
    end

    assign abort_req       = abort_r;
    assign key_found       = key_found_r;
    assign check_done      = done_r;
    assign bytes_checked   = cnt_r;
    assign first_bad_index = bad_idx_r;

`ifdef MSG_CAPTURE_EN
    logic [7:0] mem_r [MSG_LEN];
    logic [7:0] rd_data_r;

    // Capture every byte examined in CHECK, the failing one included; contents survive reset
    always_ff @(posedge clk) begin
        if (reset && accept_s) begin
            mem_r[cnt_r[CNT_W-2:0]] <= byte_data;
        end else begin
            mem_r[cnt_r[CNT_W-2:0]] <= mem_r[cnt_r[CNT_W-2:0]];
        end
    end

    // Registered readback port
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_r <= 8'h00;
        end else if ({1'b0, rd_addr} < CNT_W'(MSG_LEN)) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= 8'h00;
        end
    end

    assign rd_data = rd_data_r;
`else
    logic unused_accept_s;
    assign unused_accept_s = accept_s;
`endif

endmodule

// File: tb/tb_msg_validator.sv
// Scoreboard bench for msg_validator: stimulus queues expected snapshots, a negedge monitor pops and compares.
module tb_msg_validator;

    localparam int MSG_LEN = 32;
    localparam int CNT_W   = 6;

    logic             clk;
    logic             reset;
    logic             start;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             abort_req;
    logic             key_found;
    logic             check_done;
    logic [CNT_W-1:0] bytes_checked;
    logic [CNT_W-1:0] first_bad_index;
`ifdef MSG_CAPTURE_EN
    logic [CNT_W-2:0] rd_addr;
    logic [7:0]       rd_data;
`endif

    typedef struct {
        string            name;
        bit               is_rd;
        logic             kf;
        logic             ab;
        logic             dn;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] bad;
        logic [7:0]       rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    msg_validator #(.MSG_LEN(MSG_LEN)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .byte_valid      (byte_valid),
        .byte_data       (byte_data),
        .abort_req       (abort_req),
        .key_found       (key_found),
        .check_done      (check_done),
        .bytes_checked   (bytes_checked),
        .first_bad_index (first_bad_index)
`ifdef MSG_CAPTURE_EN
        ,
        .rd_addr         (rd_addr),
        .rd_data         (rd_data)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Monitor: compare one queued expectation per falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (e.is_rd) begin
`ifdef MSG_CAPTURE_EN
                    if (rd_data !== e.rd) begin
                        failures++;
                        $display("FAIL %s: rd_data got %02h expected %02h", e.name, rd_data, e.rd);
                    end
`endif
                end else if (key_found !== e.kf || abort_req !== e.ab || check_done !== e.dn ||
                             bytes_checked !== e.cnt || first_bad_index !== e.bad) begin
                    failures++;
                    $display("FAIL %s: got kf=%0b ab=%0b dn=%0b cnt=%0d bad=%0d expected kf=%0b ab=%0b dn=%0b cnt=%0d bad=%0d",
                             e.name, key_found, abort_req, check_done, bytes_checked, first_bad_index,
                             e.kf, e.ab, e.dn, e.cnt, e.bad);
                end
            end
        end
    end

    task automatic step(input logic s, input logic v, input logic [7:0] d);
        start      = s;
        byte_valid = v;
        byte_data  = d;
        @(posedge clk);
        #1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'hFF;
    endtask

    task automatic expect_out(input string n, input logic kf, input logic ab, input logic dn,
                              input int cnt, input int bad);
        exp_t e;
        e.name  = n;
        e.is_rd = 1'b0;
        e.kf    = kf;
        e.ab    = ab;
        e.dn    = dn;
        e.cnt   = CNT_W'(cnt);
        e.bad   = CNT_W'(bad);
        e.rd    = 8'h00;
        exp_q.push_back(e);
    endtask

`ifdef MSG_CAPTURE_EN
    task automatic expect_rd(input string n, input logic [7:0] d);
        exp_t e;
        e.name  = n;
        e.is_rd = 1'b1;
        e.kf    = 1'b0;
        e.ab    = 1'b0;
        e.dn    = 1'b0;
        e.cnt   = CNT_W'(0);
        e.bad   = CNT_W'(0);
        e.rd    = d;
        exp_q.push_back(e);
    endtask
`endif

    task automatic single_fail(input logic [7:0] b);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, b);
        expect_out($sformatf("fail_idx0_%02h", b), 1'b0, 1'b1, 1'b1, 0, 0);
    endtask

    initial begin
        string      msg;
        logic [7:0] b;
        logic [7:0] bad_set [7];
        logic [7:0] good_set [3];

        msg = "the quick brown fox jumps over t";
        bad_set[0] = 8'h60; bad_set[1] = 8'h7B; bad_set[2] = 8'h1F; bad_set[3] = 8'h21;
        bad_set[4] = 8'h41; bad_set[5] = 8'h00; bad_set[6] = 8'hFF;
        good_set[0] = 8'h20; good_set[1] = 8'h61; good_set[2] = 8'h7A;
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
`ifdef MSG_CAPTURE_EN
        rd_addr    = '0;
`endif

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            start      = 1'($urandom_range(0, 1));
            byte_valid = 1'($urandom_range(0, 1));
            byte_data  = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
        expect_out("reset_state", 1'b0, 1'b0, 1'b0, 0, 0);
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h61);
        expect_out("idle_ignores_byte", 1'b0, 1'b0, 1'b0, 0, 0);

        // Full passing message, back to back
        step(1'b1, 1'b0, 8'h00);
        expect_out("start_clears", 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < MSG_LEN; i++) begin
            b = msg[i];
            step(1'b0, 1'b1, b);
            if (i == 15) expect_out("pass_midway", 1'b0, 1'b0, 1'b0, 16, 0);
            if (i == 30) expect_out("pass_31_no_verdict", 1'b0, 1'b0, 1'b0, 31, 0);
        end
        expect_out("pass_verdict", 1'b1, 1'b0, 1'b1, 32, 0);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h61);
        expect_out("pass_frozen", 1'b1, 1'b0, 1'b1, 32, 0);
`ifdef MSG_CAPTURE_EN
        for (int i = 0; i < MSG_LEN; i++) begin
            rd_addr = (CNT_W-1)'(i);
            step(1'b0, 1'b0, 8'h00);
            b = msg[i];
            expect_rd($sformatf("capture_rd_%0d", i), b);
        end
`endif

        // Early fail at index 2
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h61);
        step(1'b0, 1'b1, 8'h20);
        expect_out("early_two_legal", 1'b0, 1'b0, 1'b0, 2, 0);
        step(1'b0, 1'b1, 8'h7B);
        expect_out("early_fail", 1'b0, 1'b1, 1'b1, 2, 2);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h61);
        expect_out("fail_frozen", 1'b0, 1'b1, 1'b1, 2, 2);
`ifdef MSG_CAPTURE_EN
        rd_addr = (CNT_W-1)'(2);
        step(1'b0, 1'b0, 8'h00);
        expect_rd("capture_fail_byte", 8'h7B);
`endif

        // Start while in FAIL
        step(1'b1, 1'b0, 8'h00);
        expect_out("restart_from_fail", 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b1, 8'h7A);
        expect_out("restart_counts", 1'b0, 1'b0, 1'b0, 1, 0);

        // Legal boundaries with random gaps; idle data is illegal but not valid
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 8'hFF);
            step(1'b0, 1'b1, good_set[i]);
        end
        repeat (2) step(1'b0, 1'b0, 8'h00);
        expect_out("legal_bounds_gaps", 1'b0, 1'b0, 1'b0, 3, 0);

        // Illegal boundaries, each its own run
        for (int i = 0; i < 7; i++) single_fail(bad_set[i]);

        // Start coinciding with a valid byte drops the byte
        step(1'b1, 1'b1, 8'h61);
        expect_out("start_drops_byte", 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b1, 8'h62);
        expect_out("after_collision", 1'b0, 1'b0, 1'b0, 1, 0);

        // Reset in the middle of a check
        step(1'b0, 1'b1, 8'h63);
        step(1'b0, 1'b1, 8'h64);
        expect_out("pre_reset_cnt", 1'b0, 1'b0, 1'b0, 3, 0);
        reset = 1'b0;
        step(1'b0, 1'b1, 8'h65);
        expect_out("reset_mid_check", 1'b0, 1'b0, 1'b0, 0, 0);
        reset = 1'b1;
        step(1'b0, 1'b1, 8'h66);
        expect_out("idle_after_reset", 1'b0, 1'b0, 1'b0, 0, 0);

        repeat (3) step(1'b0, 1'b0, 8'h00);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
